swt_led_ctrl: RTL and testbench

- Parametrised switch-to-LED controller. Next generation of the board's combinational switch/LED logic.
- Synchronises and debounces N_CH slide switches plus one mode push-button.
- Drives N_CH registered LEDs in one of four selectable display modes: direct, inverted, blink, chase.
- Sits at the board I/O boundary, between the physical switches/button and the LED pins.

---
 rtl/swt_led_pkg.sv | 15 +
 rtl/sw_debounce.sv | 43 ++++
 rtl/swt_led_ctrl.sv | 117 +++++++++++
 tb/tb_swt_led_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/swt_led_pkg.sv
// Shared types for the switch-to-LED controller.
//   MODE_W : width of the display-mode register
//   mode_e : display modes, advanced in order by the mode button
package swt_led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_DIRECT = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_e;

endpackage

// File: rtl/sw_debounce.sv
// Single-bit 2-flop synchroniser followed by a stability-counter debouncer.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous input
//   db         : debounced output, changes only after DEB_CYCLES stable cycles
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            db  <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any cycle agreeing with db restarts the stability window, so a
            // glitch shorter than DEB_CYCLES never propagates.
            if (s2 != db) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/swt_led_ctrl.sv
// Switch-to-LED controller: debounces N_CH switches plus a mode button and
// drives registered LEDs in direct / invert / blink / chase mode.
//   clk, rst_n : clock, async active-low reset
//   swt        : raw slide switches (async)
//   btn_mode   : raw mode button, active-high (async)
//   led        : registered LED drive
//   mode       : current display mode
module swt_led_ctrl
    import swt_led_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int DEB_CYCLES = 4,
    parameter int BLINK_DIV  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   swt,
    input  logic              btn_mode,
    output logic [N_CH-1:0]   led,
    output logic [MODE_W-1:0] mode
);

    localparam int POS_W = $clog2(N_CH);
    localparam int PRE_W = $clog2(BLINK_DIV + 1);
    localparam logic [N_CH-1:0] LED_ONE = N_CH'(1);

    // Bit N_CH carries the button; the rest are the switches.
    logic [N_CH:0] raw, db;
    logic [N_CH-1:0] swt_db;
    logic            btn_db;

    assign raw    = {btn_mode, swt};
    assign swt_db = db[N_CH-1:0];
    assign btn_db = db[N_CH];

    for (genvar i = 0; i <= N_CH; i++) begin : g_deb
        sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .db    (db[i])
        );
    end

    mode_e            mode_q, mode_d;
    logic             btn_prev;
    logic [PRE_W-1:0] presc;
    logic             blink_phase;
    logic [POS_W-1:0] pos;
    logic [N_CH-1:0]  led_d;
    logic             mode_chg, tick;

    assign mode_chg = btn_db & ~btn_prev;
    assign tick     = (presc == PRE_W'(BLINK_DIV - 1));

    // Mode FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= MODE_DIRECT;
        else        mode_q <= mode_d;
    end

    // Mode FSM: next state
    always_comb begin
        mode_d = mode_q;
        if (mode_chg) begin
            case (mode_q)
                MODE_DIRECT: mode_d = MODE_INVERT;
                MODE_INVERT: mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_CHASE;
                default:     mode_d = MODE_DIRECT;
            endcase
        end
    end

    // Mode FSM: output (LED pattern for the current mode)
    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_DIRECT: led_d = swt_db;
            MODE_INVERT: led_d = ~swt_db;
            MODE_BLINK:  led_d = blink_phase ? swt_db : '0;
            default:     led_d = LED_ONE << pos;
        endcase
    end

    // Prescaler, blink phase, chase position and LED register. A mode change
    // restarts the animation and overrides a coinciding tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev    <= 1'b0;
            presc       <= '0;
            blink_phase <= 1'b0;
            pos         <= '0;
            led         <= '0;
        end else begin
            btn_prev <= btn_db;
            led      <= led_d;
            if (mode_chg) begin
                presc       <= '0;
                blink_phase <= 1'b1;
                pos         <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    blink_phase <= ~blink_phase;
                    if (swt_db[0])
                        pos <= (pos == '0) ? POS_W'(N_CH - 1) : pos - 1'b1;
                    else
                        pos <= (pos == POS_W'(N_CH - 1)) ? '0 : pos + 1'b1;
                end
            end
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_swt_led_ctrl.sv
// Testbench for swt_led_ctrl: table vectors, hand-written multi-cycle
// sequences, and a randomized run against a behavioural reference model.
module tb_swt_led_ctrl;

    localparam int N   = 8;
    localparam int DEB = 4;
    localparam int BD  = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] swt = '0;
    logic         btn_mode = 1'b0;
    logic [N-1:0] led;
    logic [1:0]   mode;

    int nchk = 0;
    int nerr = 0;
    bit sb_en = 1'b0;

    swt_led_ctrl #(.N_CH(N), .DEB_CYCLES(DEB), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .swt      (swt),
        .btn_mode (btn_mode),
        .led      (led),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw samples and synchronised samples are kept as history queues; a bit's
    // debounced value flips when the last DEB synchronised samples all differ
    // from it.
    logic [N:0]   samp_q[$];
    logic [N:0]   s2_q[$];
    logic [N:0]   m_db, m_s2;
    logic         m_prev, m_tick, m_chg, m_all;
    int           m_mode, m_phase, m_pos, m_presc;
    logic [N-1:0] m_led;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q.delete(); s2_q.delete();
            m_db = '0; m_prev = 1'b0; m_mode = 0; m_phase = 0; m_pos = 0;
            m_presc = 0; m_led = '0;
        end else begin
            m_s2 = (samp_q.size() >= 2) ? samp_q[1] : '0;
            samp_q.push_front({btn_mode, swt});
            if (samp_q.size() > 2) void'(samp_q.pop_back());
            s2_q.push_front(m_s2);
            if (s2_q.size() > DEB) void'(s2_q.pop_back());

            case (m_mode)
                0:       m_led = m_db[N-1:0];
                1:       m_led = ~m_db[N-1:0];
                2:       m_led = (m_phase != 0) ? m_db[N-1:0] : '0;
                default: m_led = N'(1 << m_pos);
            endcase

            m_tick = (m_presc == BD - 1);
            m_chg  = m_db[N] && !m_prev;
            m_prev = m_db[N];
            if (m_chg) begin
                m_mode = (m_mode + 1) % 4;
                m_presc = 0; m_phase = 1; m_pos = 0;
            end else begin
                m_presc = (m_presc + 1) % BD;
                if (m_tick) begin
                    m_phase = 1 - m_phase;
                    m_pos = m_db[0] ? (m_pos + N - 1) % N : (m_pos + 1) % N;
                end
            end

            if (s2_q.size() == DEB) begin
                for (int b = 0; b <= N; b++) begin
                    m_all = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (s2_q[k][b] == m_db[b]) m_all = 1'b0;
                    if (m_all) m_db[b] = ~m_db[b];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            check("sb_led", 32'(led), 32'(m_led));
            check("sb_mode", 32'(mode), 32'(m_mode));
        end
    end

    // ---------------- helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Call at a negedge with rst_n just released and swt held at v.
    task automatic chk_latency(input logic [N-1:0] v);
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            check($sformatf("latency_e%0d", e), 32'(led), (e < 7) ? 32'h0 : 32'(v));
        end
        check("latency_mode", 32'(mode), 32'h0);
    endtask

    typedef struct {
        logic [N-1:0] swt;
        logic         btn;
        int           cyc;
        logic [N-1:0] led;
        logic [1:0]   mode;
        logic         chk_led;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [N-1:0] seen, prev;
        logic [1:0]   pm;
        int           nchg, k;
        bit           found;

        tbl[0] = '{8'h5A, 1'b0, 10, 8'h5A, 2'd0, 1'b1};
        tbl[1] = '{8'h5A, 1'b1, 10, 8'hA5, 2'd1, 1'b1};
        tbl[2] = '{8'h5A, 1'b0, 10, 8'hA5, 2'd1, 1'b1};
        tbl[3] = '{8'hF0, 1'b0, 10, 8'h0F, 2'd1, 1'b1};
        tbl[4] = '{8'hF0, 1'b1, 10, 8'h00, 2'd2, 1'b0};
        tbl[5] = '{8'hF0, 1'b0, 10, 8'h00, 2'd2, 1'b0};
        tbl[6] = '{8'hF0, 1'b1, 10, 8'h00, 2'd3, 1'b0};
        tbl[7] = '{8'hF0, 1'b0, 10, 8'h00, 2'd3, 1'b0};
        tbl[8] = '{8'hF0, 1'b1, 10, 8'hF0, 2'd0, 1'b1};
        tbl[9] = '{8'h81, 1'b0, 10, 8'h81, 2'd0, 1'b1};

        // Reset state and release latency with all switches on
        swt = 8'hFF;
        cycles(3);
        check("reset_led", 32'(led), 32'h0);
        check("reset_mode", 32'(mode), 32'h0);
        rst_n = 1'b1;
        chk_latency(8'hFF);

        // Glitch rejection: 3-cycle pulse filtered, 4-cycle pulse passes
        swt = 8'h00;
        cycles(10);
        swt = 8'h08; cycles(3); swt = 8'h00;
        seen = '0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= led; end
        check("glitch3", 32'(seen), 32'h0);
        swt = 8'h08; cycles(4); swt = 8'h00;
        seen = '0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= led; end
        check("pulse4_seen", 32'(seen), 32'h08);
        check("pulse4_end", 32'(led), 32'h00);

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            swt = tbl[i].swt; btn_mode = tbl[i].btn;
            cycles(tbl[i].cyc);
            if (tbl[i].chk_led) check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
            check($sformatf("tbl%0d_mode", i), 32'(mode), 32'(tbl[i].mode));
        end
        btn_mode = 1'b0;

        // Long press gives exactly one advance
        swt = 8'h3C; cycles(10);
        btn_mode = 1'b1; nchg = 0; pm = mode;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mode != pm) nchg++;
            pm = mode;
        end
        btn_mode = 1'b0; cycles(10);
        check("hold_nchg", 32'(nchg), 32'd1);
        check("hold_mode", 32'(mode), 32'd1);
        check("hold_led", 32'(led), 32'hC3);

        // Blink: first phase shows the switches right after the change
        swt = 8'hA5; cycles(10);
        btn_mode = 1'b1; k = 0;
        while (mode != 2'd2 && k < 20) begin @(negedge clk); k++; end
        check("blink_mode", 32'(mode), 32'd2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", i), 32'(led), ((i / 3) % 2 == 0) ? 32'hA5 : 32'h00);
        end
        btn_mode = 1'b0;

        // Chase up with wrap 80 -> 01
        swt = 8'h00; cycles(10);
        btn_mode = 1'b1; k = 0;
        while (mode != 2'd3 && k < 20) begin @(negedge clk); k++; end
        check("chase_mode", 32'(mode), 32'd3);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check($sformatf("chase_up_%0d", i), 32'(led), 32'(1 << ((i / 3) % 8)));
        end
        btn_mode = 1'b0;

        // Chase down with wrap 01 -> 80
        swt = 8'h01; cycles(10);
        prev = led; nchg = 0;
        for (int i = 0; i < 60 && nchg < 9; i++) begin
            @(negedge clk);
            if (led != prev) begin
                check("chase_down", 32'(led), 32'({prev[0], prev[N-1:1]}));
                prev = led; nchg++;
            end
        end
        check("chase_down_steps", 32'(nchg), 32'd9);

        // Asynchronous reset mid-chase at pos 5
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (led == 8'h20) found = 1'b1;
        end
        check("chase_pos5", 32'(led), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_mode", 32'(mode), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_latency(8'h01);
        cycles(10);
        check("post_rst_mode", 32'(mode), 32'h0);

        // Randomized run against the reference model
        sb_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) swt = N'($urandom);
            if ($urandom_range(15) == 0) btn_mode = ~btn_mode;
            if (i == 1500) #2 rst_n = 1'b0;
            if (i == 1503) #2 rst_n = 1'b1;
        end
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
